reg_file: RTL and testbench
===========================

# reg_file

Parametrised multi-port register file: DEPTH words of WIDTH bits, one write port with per-byte strobes, two independent read ports, optional hardwired-zero entry 0 and optional write-to-read bypass. It generalises the single-bit write-enabled storage flip-flop into the processor's architectural register file. It sits between decode (read addresses) and writeback (write port).

## Interface
- WIDTH, 32: word width in bits; must be a multiple of 8.
- DEPTH, 32: number of registers; need not be a power of two.
- ZERO_REG, 1: 1 = entry 0 always reads 0 and ignores writes.
- BYPASS, 1: 1 = same-cycle write data is forwarded to matching reads.
- ADDR_W, $clog2(DEPTH): address width (derived, not overridden).
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  WIDTH  write data.
- wstrb  in  WIDTH/8  byte strobes; bit i enables wdata[8i+7:8i].
- raddr_a  in  ADDR_W  read port A address.
- rdata_a  out  WIDTH  read port A data.
- raddr_b  in  ADDR_W  read port B address.
- rdata_b  out  WIDTH  read port B data.

## Operation
- Storage: DEPTH x WIDTH flops; no RAM inference required.
- Write: on rising clk with reset_n=1, we=1, waddr valid → bytes of entry waddr with wstrb[i]=1 take wdata bytes; other bytes hold.
- Write ignored when: we=0; wstrb=0; waddr ≥ DEPTH; ZERO_REG=1 and waddr=0.
- Reads combinational from stored array, per port independently; both ports may address the same entry.
- Read of waddr ≥ DEPTH returns 0. Read of entry 0 with ZERO_REG=1 returns 0.
- Bypass (BYPASS=1): if an effective write (see ignore rules) targets a read port's address this cycle, that port returns the merged word: strobed bytes from wdata, unstrobed bytes from stored value. Applies to both ports at once.
- BYPASS=0: reads return pre-write contents until the edge; new value visible the cycle after.
- Reset: reset_n=0 at a rising edge clears every entry to 0; a write presented in the same cycle is discarded. Bypass is suppressed while reset_n=0 (reads return stored contents, which are 0 after the first reset edge).

## Timing
- Write latency: 1 edge; read latency: 0 cycles (combinational), 0 for bypass.
- After reset: all reads return 0 from the cycle following the first reset_n=0 edge.
- Reset mid-operation: overrides any pending write; no partial-byte update survives.
- No handshakes; we is accepted every cycle, back-to-back writes to the same address are legal, last edge wins.
- Critical path: raddr decode → DEPTH:1 mux → bypass mux → rdata; bypass adds one compare + byte mux.

## Structure
- Shared package: ADDR_W derivation function, byte-lane count constant (WIDTH/8), zero-word constant.
- One sub-module natural: reg_file_read_port (address decode, range check, zero-reg gating, bypass merge), instantiated twice; top holds storage array and write logic.

## Test plan
- Reset: write 0xDEADBEEF to r5, pulse reset_n=0 one edge → rdata_a(r5)=0x00000000; write with reset_n=0 to r7 → r7 stays 0.
- Byte strobes: r3=0x11223344, then wdata=0xAABBCCDD, wstrb=4'b0101 → r3=0x11BB33DD next cycle.
- Zero reg: ZERO_REG=1, write 0xFFFFFFFF to r0 → both ports read 0 same and next cycle; ZERO_REG=0 → reads 0xFFFFFFFF next cycle.
- Bypass: r9=0x00000001, same-cycle write 0x12345678 wstrb=4'b0011 to r9, raddr_a=raddr_b=9 → both read 0x00005678 that cycle (BYPASS=1), 0x00000001 (BYPASS=0); both 0x00005678 next cycle.
- Out-of-range: DEPTH=24, write to address 30 → no entry changes; read address 30 → 0.
- Back-to-back: writes 0x1, 0x2, 0x3 to r4 on consecutive edges with port B tracking r4 → rdata_b sequence 0x1, 0x2, 0x3 (BYPASS=1, same cycle) or one cycle later (BYPASS=0).

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the architectural register file.
package reg_file_pkg;

    localparam int BYTE_W = 8;

    function automatic int addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int lanes(input int width);
        return width / BYTE_W;
    endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: decode, range check, zero gating, bypass merge.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int ADDR_W   = addr_w(DEPTH)
) (
    input  logic [WIDTH-1:0]       mem [DEPTH],
    input  logic [ADDR_W-1:0]      raddr,
    input  logic                   fwd,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [WIDTH/8-1:0]     wstrb,
    output logic [WIDTH-1:0]       rdata
);

    localparam int LANES = lanes(WIDTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic             in_range;
    logic             hit;
    logic [WIDTH-1:0] stored;
    logic [WIDTH-1:0] merged;

    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full
            assign in_range = 1'b1;
        end else begin : g_part
            assign in_range = ({1'b0, raddr} < DEPTH_C);
        end
    endgenerate

    always_comb begin
        stored = in_range ? mem[raddr] : '0;
        hit    = (BYPASS != 0) && fwd && (waddr == raddr);
        merged = stored;
        for (int l = 0; l < LANES; l++) begin
            if (wstrb[l]) merged[8*l +: 8] = wdata[8*l +: 8];
        end
        rdata = hit ? merged : stored;
        // Entry 0 stays zero even if something slipped into the array
        if ((ZERO_REG != 0) && (raddr == '0)) rdata = '0;
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file: byte-strobed write port, two read ports.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int ADDR_W   = addr_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [WIDTH/8-1:0]     wstrb,
    input  logic [ADDR_W-1:0]      raddr_a,
    output logic [WIDTH-1:0]       rdata_a,
    input  logic [ADDR_W-1:0]      raddr_b,
    output logic [WIDTH-1:0]       rdata_b
);

    localparam int LANES = lanes(WIDTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             w_in_range;
    logic             wr_eff;
    logic             fwd;

    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full
            assign w_in_range = 1'b1;
        end else begin : g_part
            assign w_in_range = ({1'b0, waddr} < DEPTH_C);
        end
    endgenerate

    assign wr_eff = we && (|wstrb) && w_in_range &&
                    !((ZERO_REG != 0) && (waddr == '0));
    // Forwarding is masked during reset: the write will be discarded
    assign fwd = wr_eff && reset_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_eff) begin
            for (int l = 0; l < LANES; l++) begin
                if (wstrb[l]) mem[waddr][8*l +: 8] <= wdata[8*l +: 8];
            end
        end
    end

    reg_file_read_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG),
        .BYPASS(BYPASS), .ADDR_W(ADDR_W)
    ) u_rd_a (
        .mem(mem), .raddr(raddr_a), .fwd(fwd), .waddr(waddr),
        .wdata(wdata), .wstrb(wstrb), .rdata(rdata_a)
    );

    reg_file_read_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG),
        .BYPASS(BYPASS), .ADDR_W(ADDR_W)
    ) u_rd_b (
        .mem(mem), .raddr(raddr_b), .fwd(fwd), .waddr(waddr),
        .wdata(wdata), .wstrb(wstrb), .rdata(rdata_b)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench: three configurations share one stimulus stream.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;

    logic [31:0] d_a, d_b, n_a, n_b, s_a, s_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // d: defaults (zero reg, bypass)
    reg_file u_d (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr),
        .wdata(wdata), .wstrb(wstrb), .raddr_a(raddr_a),
        .rdata_a(d_a), .raddr_b(raddr_b), .rdata_b(d_b)
    );

    // n: no zero reg, no bypass
    reg_file #(.ZERO_REG(0), .BYPASS(0)) u_n (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr),
        .wdata(wdata), .wstrb(wstrb), .raddr_a(raddr_a),
        .rdata_a(n_a), .raddr_b(raddr_b), .rdata_b(n_b)
    );

    // s: 24 entries, 5-bit address leaves 24..31 unmapped
    reg_file #(.DEPTH(24)) u_s (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr),
        .wdata(wdata), .wstrb(wstrb), .raddr_a(raddr_a),
        .rdata_a(s_a), .raddr_b(raddr_b), .rdata_b(s_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        we = 1'b1;
        waddr = a;
        wdata = d;
        wstrb = s;
    endtask

    initial begin
        reset_n = 1'b0;
        we = 1'b0;
        waddr = '0;
        wdata = '0;
        wstrb = '0;
        raddr_a = '0;
        raddr_b = '0;
        tick();
        reset_n = 1'b1;
        raddr_a = 5'd5;
        #1;
        chk("reset_d_r5", d_a, 32'h0);
        chk("reset_n_r5", n_a, 32'h0);

        // reset clears a written entry
        wr(5'd5, 32'hDEADBEEF, 4'hF);
        tick();
        we = 1'b0;
        #1;
        chk("wr_r5", d_a, 32'hDEADBEEF);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        chk("rst_clr_d_r5", d_a, 32'h0);
        chk("rst_clr_n_r5", n_a, 32'h0);

        // write during reset is dropped and not forwarded
        reset_n = 1'b0;
        wr(5'd7, 32'h12345678, 4'hF);
        raddr_b = 5'd7;
        #1;
        chk("rst_nofwd_r7", d_b, 32'h0);
        tick();
        reset_n = 1'b1;
        we = 1'b0;
        #1;
        chk("rst_wr_d_r7", d_b, 32'h0);
        chk("rst_wr_n_r7", n_b, 32'h0);

        // byte strobes
        wr(5'd3, 32'h11223344, 4'hF);
        tick();
        wr(5'd3, 32'hAABBCCDD, 4'b0101);
        raddr_a = 5'd3;
        #1;
        chk("strb_fwd_d", d_a, 32'h11BB33DD);
        chk("strb_old_n", n_a, 32'h11223344);
        tick();
        we = 1'b0;
        #1;
        chk("strb_d", d_a, 32'h11BB33DD);
        chk("strb_n", n_a, 32'h11BB33DD);

        // zero register
        wr(5'd0, 32'hFFFFFFFF, 4'hF);
        raddr_a = 5'd0;
        raddr_b = 5'd0;
        #1;
        chk("zr_now_d_a", d_a, 32'h0);
        chk("zr_now_d_b", d_b, 32'h0);
        chk("zr_now_n_a", n_a, 32'h0);
        tick();
        we = 1'b0;
        #1;
        chk("zr_next_d_a", d_a, 32'h0);
        chk("zr_next_d_b", d_b, 32'h0);
        chk("zr_next_n_a", n_a, 32'hFFFFFFFF);
        chk("zr_next_n_b", n_b, 32'hFFFFFFFF);

        // bypass merge on both ports
        wr(5'd9, 32'h00000001, 4'hF);
        tick();
        wr(5'd9, 32'h12345678, 4'b0011);
        raddr_a = 5'd9;
        raddr_b = 5'd9;
        #1;
        chk("byp_d_a", d_a, 32'h00005678);
        chk("byp_d_b", d_b, 32'h00005678);
        chk("nobyp_n_a", n_a, 32'h00000001);
        chk("nobyp_n_b", n_b, 32'h00000001);
        tick();
        we = 1'b0;
        #1;
        chk("byp_next_d", d_a, 32'h00005678);
        chk("byp_next_n", n_b, 32'h00005678);

        // out of range on the 24-entry instance
        wr(5'd30, 32'hCAFEF00D, 4'hF);
        raddr_a = 5'd30;
        #1;
        chk("oor_nofwd_s", s_a, 32'h0);
        chk("inr_fwd_d", d_a, 32'hCAFEF00D);
        tick();
        we = 1'b0;
        #1;
        chk("oor_rd_s", s_a, 32'h0);
        chk("oor_keep_s_r9", s_b, 32'h00005678);
        chk("inr_d_r30", d_a, 32'hCAFEF00D);
        wr(5'd23, 32'h5A5A5A5A, 4'hF);
        tick();
        we = 1'b0;
        raddr_a = 5'd23;
        raddr_b = 5'd24;
        #1;
        chk("last_s_r23", s_a, 32'h5A5A5A5A);
        chk("oor_s_r24", s_b, 32'h0);

        // back-to-back writes, port B tracking r4
        raddr_b = 5'd4;
        wr(5'd4, 32'h1, 4'hF);
        #1;
        chk("b2b1_d", d_b, 32'h1);
        chk("b2b1_n", n_b, 32'h0);
        tick();
        wr(5'd4, 32'h2, 4'hF);
        #1;
        chk("b2b2_d", d_b, 32'h2);
        chk("b2b2_n", n_b, 32'h1);
        tick();
        wr(5'd4, 32'h3, 4'hF);
        #1;
        chk("b2b3_d", d_b, 32'h3);
        chk("b2b3_n", n_b, 32'h2);
        tick();
        we = 1'b0;
        #1;
        chk("b2b4_d", d_b, 32'h3);
        chk("b2b4_n", n_b, 32'h3);

        // zero strobe is not a write
        wr(5'd4, 32'hFFFFFFFF, 4'h0);
        #1;
        chk("nostrb_fwd", d_b, 32'h3);
        tick();
        we = 1'b0;
        #1;
        chk("nostrb_keep", n_b, 32'h3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
